// File: rtl/store_byte_control_write_data.sv
// Store byte-lane control: turns a core SB/SH/SW request into one or two
// word-wide SRAM writes with active-low byte enables and lane-shifted data.
// A store that crosses a word boundary is split into two consecutive beats.
module store_byte_control_write_data #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [31:0]          st_addr,
    input  logic [DATA_SIZE-1:0] st_data,
    input  logic [1:0]           st_size,
    output logic                 st_done,
    output logic                 st_err,
    input  logic                 mem_stall,
    output logic                 mem_cs,
    output logic [3:0]           mem_web,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_di
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Registered outputs and their next values
    logic                 st_ready_reg, st_ready_next;
    logic                 st_done_reg, st_done_next;
    logic                 st_err_reg, st_err_next;
    logic                 mem_cs_reg, mem_cs_next;
    logic [3:0]           mem_web_reg, mem_web_next;
    logic [ADDR_SIZE-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_SIZE-1:0] mem_di_reg, mem_di_next;

    // Second-beat context captured at accept
    logic                 pend_reg, pend_next;
    logic [3:0]           hi_web_reg, hi_web_next;
    logic [DATA_SIZE-1:0] hi_di_reg, hi_di_next;

    // Accept-time lane computation
    logic [1:0]             off;
    logic [3:0]             mask;
    logic [7:0]             wmask;
    logic [2*DATA_SIZE-1:0] wdata;
    logic [ADDR_SIZE-1:0]   waddr;
    logic                   accept;

    assign accept = st_valid && st_ready_reg;
    assign off    = st_addr[1:0];
    assign waddr  = st_addr[ADDR_SIZE+1:2];

    // Byte mask for the request size before lane shifting
    always_comb begin
        mask = 4'b0000;
        case (st_size)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
    end

    // Shift mask and data into their byte lanes across a two-word window
    always_comb begin
        wmask = {4'b0000, mask} << off;
        wdata = {{DATA_SIZE{1'b0}}, st_data} << {off, 3'b000};
    end

    // Next-state and next-output logic; default is to hold everything
    always_comb begin
        state_next    = state_reg;
        st_ready_next = st_ready_reg;
        st_done_next  = 1'b0;
        st_err_next   = 1'b0;
        mem_cs_next   = mem_cs_reg;
        mem_web_next  = mem_web_reg;
        mem_addr_next = mem_addr_reg;
        mem_di_next   = mem_di_reg;
        pend_next     = pend_reg;
        hi_web_next   = hi_web_reg;
        hi_di_next    = hi_di_reg;

        case (state_reg)
            IDLE: begin
                st_ready_next = 1'b1;
                if (accept) begin
                    if (st_size == 2'd3) begin
                        // Reserved size: flag it and stay ready, no write
                        st_err_next = 1'b1;
                    end else begin
                        state_next    = BEAT0;
                        st_ready_next = 1'b0;
                        mem_cs_next   = 1'b1;
                        mem_addr_next = waddr;
                        mem_web_next  = ~wmask[3:0];
                        mem_di_next   = wdata[DATA_SIZE-1:0];
                        pend_next     = (wmask[7:4] != 4'b0000);
                        hi_web_next   = ~wmask[7:4];
                        hi_di_next    = wdata[2*DATA_SIZE-1:DATA_SIZE];
                    end
                end
            end
            BEAT0: begin
                if (!mem_stall) begin
                    if (pend_reg) begin
                        state_next    = BEAT1;
                        mem_addr_next = mem_addr_reg + 1'b1;
                        mem_web_next  = hi_web_reg;
                        mem_di_next   = hi_di_reg;
                        pend_next     = 1'b0;
                    end else begin
                        state_next    = IDLE;
                        st_ready_next = 1'b1;
                        st_done_next  = 1'b1;
                        mem_cs_next   = 1'b0;
                        mem_web_next  = 4'hF;
                    end
                end
            end
            BEAT1: begin
                if (!mem_stall) begin
                    state_next    = IDLE;
                    st_ready_next = 1'b1;
                    st_done_next  = 1'b1;
                    mem_cs_next   = 1'b0;
                    mem_web_next  = 4'hF;
                end
            end
            default: begin
                state_next    = IDLE;
                st_ready_next = 1'b1;
                mem_cs_next   = 1'b0;
                mem_web_next  = 4'hF;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            st_ready_reg <= 1'b0;
            st_done_reg  <= 1'b0;
            st_err_reg   <= 1'b0;
            mem_cs_reg   <= 1'b0;
            mem_web_reg  <= 4'hF;
            mem_addr_reg <= '0;
            mem_di_reg   <= '0;
            pend_reg     <= 1'b0;
            hi_web_reg   <= 4'hF;
            hi_di_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            st_ready_reg <= st_ready_next;
            st_done_reg  <= st_done_next;
            st_err_reg   <= st_err_next;
            mem_cs_reg   <= mem_cs_next;
            mem_web_reg  <= mem_web_next;
            mem_addr_reg <= mem_addr_next;
            mem_di_reg   <= mem_di_next;
            pend_reg     <= pend_next;
            hi_web_reg   <= hi_web_next;
            hi_di_reg    <= hi_di_next;
        end
    end

    assign st_ready = st_ready_reg;
    assign st_done  = st_done_reg;
    assign st_err   = st_err_reg;
    assign mem_cs   = mem_cs_reg;
    assign mem_web  = mem_web_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_di   = mem_di_reg;

endmodule

// File: tb/tb_store_byte_control_write_data.sv
// Directed bench for the store byte-lane controller.
module tb_store_byte_control_write_data;

    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 st_valid;
    logic                 st_ready;
    logic [31:0]          st_addr;
    logic [DATA_SIZE-1:0] st_data;
    logic [1:0]           st_size;
    logic                 st_done;
    logic                 st_err;
    logic                 mem_stall;
    logic                 mem_cs;
    logic [3:0]           mem_web;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_di;

    int checks = 0;
    int errors = 0;

    store_byte_control_write_data #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_SIZE(ADDR_SIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_stall (mem_stall),
        .mem_cs    (mem_cs),
        .mem_web   (mem_web),
        .mem_addr  (mem_addr),
        .mem_di    (mem_di)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the edge for sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then drop valid
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        step();
        st_valid = 1'b0;
        $display("request addr=0x%0h data=0x%0h size=%0d", a, d, s);
    endtask

    // Check a full write beat
    task automatic chk_beat(input string tag, input logic [13:0] a, input logic [3:0] web,
                            input logic [31:0] di);
        chk({tag, ".cs"},   64'(mem_cs), 64'd1);
        chk({tag, ".addr"}, 64'(mem_addr), 64'(a));
        chk({tag, ".web"},  64'(mem_web), 64'(web));
        chk({tag, ".di"},   64'(mem_di), 64'(di));
        chk({tag, ".done"}, 64'(st_done), 64'd0);
        chk({tag, ".rdy"},  64'(st_ready), 64'd0);
        $display("beat %s addr=0x%0h web=%b di=0x%0h", tag, mem_addr, mem_web, mem_di);
    endtask

    // Check the completion cycle
    task automatic chk_done(input string tag);
        chk({tag, ".done"}, 64'(st_done), 64'd1);
        chk({tag, ".cs"},   64'(mem_cs), 64'd0);
        chk({tag, ".web"},  64'(mem_web), 64'hF);
        chk({tag, ".rdy"},  64'(st_ready), 64'd1);
        $display("done %s", tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rdy"},  64'(st_ready), 64'd0);
        chk({tag, ".done"}, 64'(st_done), 64'd0);
        chk({tag, ".err"},  64'(st_err), 64'd0);
        chk({tag, ".cs"},   64'(mem_cs), 64'd0);
        chk({tag, ".web"},  64'(mem_web), 64'hF);
        chk({tag, ".addr"}, 64'(mem_addr), 64'd0);
        chk({tag, ".di"},   64'(mem_di), 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_size   = '0;
        mem_stall = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b1;
        step();
        chk("ready_after_reset", 64'(st_ready), 64'd1);

        // Aligned word
        issue(32'h100, 32'hDEADBEEF, 2'd2);
        chk_beat("sw_aligned", 14'h40, 4'h0, 32'hDEADBEEF);
        step();
        chk_done("sw_aligned");
        step();
        chk("sw_aligned.done_pulse", 64'(st_done), 64'd0);

        // Byte in top lane
        issue(32'h103, 32'h000000A5, 2'd0);
        chk_beat("sb_lane3", 14'h40, 4'b0111, 32'hA500_0000);
        step();
        chk_done("sb_lane3");

        // Halfword crossing a word boundary; inputs changed while busy
        issue(32'h203, 32'h00001234, 2'd1);
        st_data = 32'hFFFF_FFFF;
        st_addr = 32'h0;
        chk_beat("sh_split0", 14'h80, 4'b0111, 32'h3400_0000);
        step();
        chk_beat("sh_split1", 14'h81, 4'b1110, 32'h0000_0012);
        step();
        chk_done("sh_split");

        // Split word with two stall cycles in the first beat
        issue(32'h102, 32'hCAFEF00D, 2'd2);
        chk_beat("sw_stall0", 14'h40, 4'b0011, 32'hF00D_0000);
        mem_stall = 1'b1;
        step();
        chk_beat("sw_hold1", 14'h40, 4'b0011, 32'hF00D_0000);
        step();
        chk_beat("sw_hold2", 14'h40, 4'b0011, 32'hF00D_0000);
        mem_stall = 1'b0;
        step();
        chk_beat("sw_stall1", 14'h41, 4'b1100, 32'h0000_CAFE);
        step();
        chk_done("sw_stall");

        // Back-to-back: accept in the st_done cycle
        issue(32'h001, 32'h0000005A, 2'd0);
        chk_beat("sb_b2b", 14'h0, 4'b1101, 32'h0000_5A00);
        step();
        chk_done("sb_b2b");

        // Reserved size
        issue(32'h104, 32'h1, 2'd3);
        chk("rsv.err",  64'(st_err), 64'd1);
        chk("rsv.done", 64'(st_done), 64'd0);
        chk("rsv.cs",   64'(mem_cs), 64'd0);
        chk("rsv.rdy",  64'(st_ready), 64'd1);
        step();
        chk("rsv.err_pulse", 64'(st_err), 64'd0);
        chk("rsv.cs2",  64'(mem_cs), 64'd0);
        $display("reserved size flagged err");

        // Split at top of memory, abandoned by reset in the first beat
        issue(32'hFFFE, 32'h11223344, 2'd2);
        chk_beat("top_beat0", 14'h3FFF, 4'b0011, 32'h3344_0000);
        rst = 1'b0;
        step();
        chk_reset_vals("midreset");
        rst = 1'b1;
        step();
        chk("midreset.no_beat1", 64'(mem_cs), 64'd0);
        chk("midreset.no_done",  64'(st_done), 64'd0);
        chk("midreset.rdy",      64'(st_ready), 64'd1);

        // Same store without reset: second beat wraps to word 0
        issue(32'hFFFE, 32'h11223344, 2'd2);
        chk_beat("wrap_beat0", 14'h3FFF, 4'b0011, 32'h3344_0000);
        step();
        chk_beat("wrap_beat1", 14'h0000, 4'b1100, 32'h0000_1122);
        step();
        chk_done("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
